counter_nb: RTL and testbench

//  Parametrised N-bit multi-mode counter. Successor to the fixed 4-bit counter.

---
 rtl/counter_nb.sv | 129 ++++++++++++
 tb/tb_counter_nb.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/counter_nb.sv
// rtl/counter_nb.sv - parametrised multi-mode counter with run-time modulus and wrap-event counter
// Optional clamp-instead-of-wrap behaviour selected by COUNTER_NB_SATURATE_EN.
module counter_nb #(
  parameter int WIDTH  = 8,
  parameter int STEP   = 3,
  parameter int WRAP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  D,
  input  logic [WIDTH-1:0]  tc,
  output logic [WIDTH-1:0]  Q,
  output logic              rco,
  output logic              load,
  output logic [WRAP_W-1:0] wraps
);

  localparam logic [1:0] MODE_UP_STEP = 2'b00;
  localparam logic [1:0] MODE_DOWN    = 2'b01;
  localparam logic [1:0] MODE_UP_ONE  = 2'b10;
  localparam logic [1:0] MODE_LOAD    = 2'b11;

  localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

  logic [WIDTH-1:0]  q_next;
  logic              rco_next;
  logic              load_next;
  logic              wrap_event;
  logic [WRAP_W-1:0] wraps_next;
  logic [WIDTH:0]    sum;
  logic [WIDTH:0]    tc_ext;
  logic              out_of_range;

  // One extra bit keeps Q+STEP from aliasing back into range at the top of the count.
  assign sum          = {1'b0, Q} + STEP_EXT;
  assign tc_ext       = {1'b0, tc};
  assign out_of_range = (Q > tc);

`ifndef COUNTER_NB_SATURATE_EN
  logic [WIDTH:0] sum_wrapped;
  assign sum_wrapped = sum - (tc_ext + 1'b1);
`endif

  always_comb begin
    q_next    = Q;
    rco_next  = 1'b0;
    load_next = 1'b0;
    if (enable) begin
      if (mode == MODE_LOAD) begin
        q_next    = D;
        load_next = 1'b1;
      end else if (out_of_range) begin
        rco_next = 1'b1;
`ifdef COUNTER_NB_SATURATE_EN
        q_next   = (mode == MODE_DOWN) ? '0 : tc;
`else
        q_next   = '0;
`endif
      end else begin
        case (mode)
          MODE_UP_STEP: begin
            if (sum <= tc_ext) begin
              q_next = sum[WIDTH-1:0];
            end else begin
              rco_next = 1'b1;
`ifdef COUNTER_NB_SATURATE_EN
              q_next   = tc;
`else
              // A large STEP against a small modulus can overshoot again after one fold.
              q_next   = (sum_wrapped > tc_ext) ? '0 : sum_wrapped[WIDTH-1:0];
`endif
            end
          end
          MODE_DOWN: begin
            if (Q == '0) begin
              rco_next = 1'b1;
`ifdef COUNTER_NB_SATURATE_EN
              q_next   = '0;
`else
              q_next   = tc;
`endif
            end else begin
              q_next = Q - 1'b1;
            end
          end
          MODE_UP_ONE: begin
            if (Q == tc) begin
              rco_next = 1'b1;
`ifdef COUNTER_NB_SATURATE_EN
              q_next   = tc;
`else
              q_next   = '0;
`endif
            end else begin
              q_next = Q + 1'b1;
            end
          end
          default: q_next = Q;
        endcase
      end
    end
  end

  // While pinned, rco stays high as a level, so only its rising edge is an event.
`ifdef COUNTER_NB_SATURATE_EN
  assign wrap_event = rco_next & ~rco;
`else
  assign wrap_event = rco_next;
`endif

  assign wraps_next = (wrap_event && (wraps != '1)) ? wraps + 1'b1 : wraps;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Q     <= '0;
      rco   <= 1'b0;
      load  <= 1'b0;
      wraps <= '0;
    end else begin
      Q     <= q_next;
      rco   <= rco_next;
      load  <= load_next;
      wraps <= wraps_next;
    end
  end

endmodule

// File: tb/tb_counter_nb.sv
// tb/tb_counter_nb.sv - vector-table bench for counter_nb (WIDTH=8, STEP=3, WRAP_W=4)
module tb_counter_nb;

  typedef struct packed {
    logic       en;
    logic [1:0] mode;
    logic [7:0] d;
    logic [7:0] tc;
    logic [7:0] q;
    logic       rco;
    logic       load;
    logic [3:0] wraps;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [1:0] mode;
  logic [7:0] D;
  logic [7:0] tc;
  logic [7:0] Q;
  logic       rco;
  logic       load;
  logic [3:0] wraps;

  int errors = 0;
  int checks = 0;

  counter_nb #(.WIDTH(8), .STEP(3), .WRAP_W(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .D(D), .tc(tc),
    .Q(Q), .rco(rco), .load(load), .wraps(wraps)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic check_all(input string name, input int idx, input logic [7:0] eq,
                           input logic erco, input logic eload, input logic [3:0] ewraps);
    check({name, ".Q"}, idx, Q, eq);
    check({name, ".rco"}, idx, {7'd0, rco}, {7'd0, erco});
    check({name, ".load"}, idx, {7'd0, load}, {7'd0, eload});
    check({name, ".wraps"}, idx, {4'd0, wraps}, {4'd0, ewraps});
  endtask

  task automatic step(input logic en, input logic [1:0] m, input logic [7:0] d, input logic [7:0] t);
    enable = en;
    mode   = m;
    D      = d;
    tc     = t;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
`ifdef COUNTER_NB_SATURATE_EN
    vecs.push_back('{1'b1, 2'd3, 8'h09, 8'd10, 8'h09, 1'b0, 1'b1, 4'd0});
    vecs.push_back('{1'b1, 2'd2, 8'h00, 8'd10, 8'd10,  1'b0, 1'b0, 4'd0});
    vecs.push_back('{1'b1, 2'd2, 8'h00, 8'd10, 8'd10,  1'b1, 1'b0, 4'd1});
    vecs.push_back('{1'b1, 2'd2, 8'h00, 8'd10, 8'd10,  1'b1, 1'b0, 4'd1});
    vecs.push_back('{1'b1, 2'd3, 8'h01, 8'd10, 8'h01, 1'b0, 1'b1, 4'd1});
    vecs.push_back('{1'b1, 2'd1, 8'h00, 8'd10, 8'h00, 1'b0, 1'b0, 4'd1});
    vecs.push_back('{1'b1, 2'd1, 8'h00, 8'd10, 8'h00, 1'b1, 1'b0, 4'd2});
    vecs.push_back('{1'b1, 2'd1, 8'h00, 8'd10, 8'h00, 1'b1, 1'b0, 4'd2});
    vecs.push_back('{1'b1, 2'd3, 8'hF5, 8'd10, 8'hF5, 1'b0, 1'b1, 4'd2});
    vecs.push_back('{1'b1, 2'd2, 8'h00, 8'd10, 8'd10,  1'b1, 1'b0, 4'd3});
    vecs.push_back('{1'b1, 2'd0, 8'h00, 8'd10, 8'd10,  1'b1, 1'b0, 4'd3});
`else
    // Mode 00 by 3 against tc=10, then a load and mode 01 through the bottom.
    vecs.push_back('{1'b1, 2'd0, 8'h00, 8'd10, 8'd3,  1'b0, 1'b0, 4'd0});
    vecs.push_back('{1'b1, 2'd0, 8'h00, 8'd10, 8'd6,  1'b0, 1'b0, 4'd0});
    vecs.push_back('{1'b1, 2'd0, 8'h00, 8'd10, 8'd9,  1'b0, 1'b0, 4'd0});
    vecs.push_back('{1'b1, 2'd0, 8'h00, 8'd10, 8'd1,  1'b1, 1'b0, 4'd1});
    vecs.push_back('{1'b1, 2'd3, 8'h02, 8'd10, 8'd2,  1'b0, 1'b1, 4'd1});
    vecs.push_back('{1'b1, 2'd1, 8'h00, 8'd10, 8'd1,  1'b0, 1'b0, 4'd1});
    vecs.push_back('{1'b1, 2'd1, 8'h00, 8'd10, 8'd0,  1'b0, 1'b0, 4'd1});
    vecs.push_back('{1'b1, 2'd1, 8'h00, 8'd10, 8'd10, 1'b1, 1'b0, 4'd2});
    vecs.push_back('{1'b1, 2'd1, 8'h00, 8'd10, 8'd9,  1'b0, 1'b0, 4'd2});
    // Load beyond tc, then the out-of-range rule.
    vecs.push_back('{1'b1, 2'd3, 8'hF5, 8'd10, 8'hF5, 1'b0, 1'b1, 4'd2});
    vecs.push_back('{1'b1, 2'd2, 8'h00, 8'd10, 8'h00, 1'b1, 1'b0, 4'd3});
    // tc=0 and double-fold in mode 00.
    vecs.push_back('{1'b1, 2'd2, 8'h00, 8'd0,  8'h00, 1'b1, 1'b0, 4'd4});
    vecs.push_back('{1'b1, 2'd0, 8'h00, 8'd0,  8'h00, 1'b1, 1'b0, 4'd5});
    vecs.push_back('{1'b1, 2'd0, 8'h00, 8'd1,  8'h01, 1'b1, 1'b0, 4'd6});
    vecs.push_back('{1'b1, 2'd0, 8'h00, 8'd1,  8'h00, 1'b1, 1'b0, 4'd7});
    // Full-width modulus: sum needs the extra bit.
    vecs.push_back('{1'b1, 2'd3, 8'hFE, 8'hFF, 8'hFE, 1'b0, 1'b1, 4'd7});
    vecs.push_back('{1'b1, 2'd0, 8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, 4'd8});
    vecs.push_back('{1'b1, 2'd3, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1, 4'd8});
    vecs.push_back('{1'b1, 2'd2, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 4'd9});
    // tc lowered below Q in mode 01.
    vecs.push_back('{1'b1, 2'd3, 8'h14, 8'hFF, 8'h14, 1'b0, 1'b1, 4'd9});
    vecs.push_back('{1'b1, 2'd1, 8'h00, 8'd10, 8'h00, 1'b1, 1'b0, 4'd10});
    // Hold with mode toggling; D and tc must be ignored.
    vecs.push_back('{1'b1, 2'd3, 8'h04, 8'd10, 8'h04, 1'b0, 1'b1, 4'd10});
    vecs.push_back('{1'b0, 2'd0, 8'h55, 8'd2,  8'h04, 1'b0, 1'b0, 4'd10});
    vecs.push_back('{1'b0, 2'd1, 8'h55, 8'd2,  8'h04, 1'b0, 1'b0, 4'd10});
    vecs.push_back('{1'b0, 2'd2, 8'h55, 8'd2,  8'h04, 1'b0, 1'b0, 4'd10});
    vecs.push_back('{1'b0, 2'd3, 8'h55, 8'd2,  8'h04, 1'b0, 1'b0, 4'd10});
    vecs.push_back('{1'b0, 2'd0, 8'h55, 8'd2,  8'h04, 1'b0, 1'b0, 4'd10});
`endif

    reset  = 1'b0;
    enable = 1'b0;
    mode   = 2'd0;
    D      = 8'h00;
    tc     = 8'd10;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("reset", 0, 8'h00, 1'b0, 1'b0, 4'd0);
    #2 reset = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].tc);
      check_all("vec", i, vecs[i].q, vecs[i].rco, vecs[i].load, vecs[i].wraps);
    end

`ifndef COUNTER_NB_SATURATE_EN
    // Drive wraps from 10 into saturation with tc=0.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'd2, 8'h00, 8'd0);
      check_all("wsat", i, 8'h00, 1'b1, 1'b0, (i + 11 > 15) ? 4'hF : 4'(i + 11));
    end
    step(1'b0, 2'd2, 8'h00, 8'd0);
    check_all("wsat_hold", 0, 8'h00, 1'b0, 1'b0, 4'hF);

    // Count to 7, then reset between edges.
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 2'd2, 8'h00, 8'd10);
      check("cnt.Q", i, Q, 8'(i + 1));
    end
    #2 reset = 1'b0;
    #1;
    check_all("async_reset", 0, 8'h00, 1'b0, 1'b0, 4'd0);
    @(posedge clk);
    #1;
    check_all("reset_held", 0, 8'h00, 1'b0, 1'b0, 4'd0);
    #2 reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_all("resume", i, 8'(i + 1), 1'b0, 1'b0, 4'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
